// File: rtl/mips32_mem_responder.sv
// Data-memory responder for the MEM stage load/store port: one request at a time,
// fixed wait states, byte-masked writes, and a response held until the initiator takes it.
module mips32_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic          access;
    logic          in_range;
    logic [AW-1:0] idx;

    assign accept   = (state == IDLE) && req_valid && req_ready;
    assign access   = (state == WAIT) && (cnt == 4'd0);
    assign in_range = addr_q < 32'(DEPTH);
    assign idx      = addr_q[AW-1:0];

    // Request capture; only loaded on an accepted handshake, so no reset needed.
    always_ff @(posedge clk1) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    // Memory array is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk1) begin
        if (access && we_q && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= WAIT;
                        cnt       <= 4'(WAIT_CYCLES);
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~in_range;
                        rsp_rdata <= (in_range && !we_q) ? mem[idx] : 32'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mips32_mem_responder.md
# mips32_mem_responder

Memory-side responder for the pipeline's load/store port: a word-addressed 32-bit data memory with a valid/ready request channel and a valid/ready response channel. The CPU data path is the initiator. This block accepts one request at a time, inserts a configurable number of wait states, performs the byte-masked write or the read, and holds the response until the initiator takes it. It sits between the MEM stage and the data memory array.

## Interface
- `DEPTH`, 1024, number of 32-bit words; legal addresses are 0..DEPTH-1
- `WAIT_CYCLES`, 2, wait states between request acceptance and access; legal range 0..15
- `clk1` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: responder can accept a request
- `req_we` in 1: 1 = write, 0 = read
- `req_addr` in 32: word address, full 32 bits compared against DEPTH
- `req_wdata` in 32: write data
- `req_be` in 4: byte enables, bit i enables byte i (`[8i+7:8i]`); ignored on reads
- `rsp_valid` out 1: response present
- `rsp_ready` in 1: initiator accepts response
- `rsp_rdata` out 32: read data; 0 for writes and errors
- `rsp_err` out 1: address out of range

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. An edge with `req_valid`&`req_ready` captures we/addr/wdata/be, loads the wait counter with WAIT_CYCLES, and moves to WAIT.
- WAIT: `req_ready`=0. Counter decrements each edge. The edge at which the counter is 0 performs the access, registers the response, and moves to RESP. With WAIT_CYCLES=0 this is the first edge after accept.
- Access for an in-range write: each byte with be=1 is written; other bytes are retained. `rsp_rdata`=0, `rsp_err`=0. Writing with be=0000 is legal, does nothing, and still responds.
- Access for an in-range read: `rsp_rdata`=Mem[addr], `rsp_err`=0.
- Out of range (addr >= DEPTH): no write, `rsp_rdata`=0, `rsp_err`=1.
- RESP: `rsp_valid`=1. `rsp_rdata`/`rsp_err` are stable until an edge with `rsp_ready`=1, which moves to IDLE and clears `rsp_valid`.
- While not in IDLE, `req_valid` is ignored and no input is sampled.
- Memory contents are not cleared by reset and survive it.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE, counter 0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=0.
- `req_ready` is registered. It rises on the first clk1 edge after `rst_n` deasserts and is 1 whenever state is IDLE.
- Accept at edge N. `rsp_valid` rises after edge N+WAIT_CYCLES+1. A write is visible in Mem after that same edge.
- Handshake at edge M clears `rsp_valid` and raises `req_ready`. The next accept is at edge M+1 at the earliest.
- Minimum transaction period is WAIT_CYCLES+3 cycles, so WAIT_CYCLES=2 gives 5 cycles.
- A read that immediately follows a write to the same address returns the new data.
- Reset asserted in WAIT aborts the transaction: no write occurs and no response is produced.
- Reset asserted in RESP drops the response; the memory write has already occurred.
- `rsp_ready` high outside RESP has no effect.

## Test plan
All scenarios use DEPTH=1024, WAIT_CYCLES=2.
- Reset: hold `rst_n` low with clock running -> `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `req_ready`=0. Release -> `req_ready`=1 after the first edge.
- Write then read: write addr 5, data 0xDEADBEEF, be 4'hF; then read addr 5 with `rsp_ready` held 1 -> each `rsp_valid` rises exactly 3 edges after accept and lasts 1 cycle. Write response: rdata 0, err 0. Read response: rdata 0xDEADBEEF, err 0.
- Byte mask: over 0xDEADBEEF at addr 5, write 0x11223344 with be 4'b0101, then read addr 5 -> 0xDE22BE44.
- Backpressure: read addr 5 with `rsp_ready`=0 for 6 cycles while `req_valid` is pulsed with addr 7 -> `rsp_valid`, rdata 0xDE22BE44 and err 0 stay constant, `req_ready`=0, and addr 7 is never accepted. Raising `rsp_ready` -> IDLE on the next edge.
- Out of range: write addr 1024, data 0xFFFFFFFF -> err 1, rdata 0. Read addr 0xFFFFFFFF -> err 1, rdata 0. Addr 1023 remains readable with err 0.
- Reset mid-wait: write addr 9 = 0x12345678, then write addr 9 = 0xCAFEF00D with `rst_n` pulsed low during WAIT -> after recovery, a read of addr 9 returns 0x12345678, and no response was produced for the aborted write.
